// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus signals between the MEM/IF stages, mem_ctrl and the RAM/IO bus.
// slave is the controller's view; master is the core pipeline plus external RAM.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
   logic              ram_r_req_i;
   logic              ram_w_req_i;
   logic [ADDR_W-1:0] ram_addr_i;
   logic [31:0]       ram_w_data_i;
   logic [1:0]        ram_state_i;
   logic              ram_done_o;
   logic [31:0]       ram_r_data_o;
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_done_o;
   logic [31:0]       if_data_o;
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;
   logic              io_buffer_full;

   modport slave (
      input  ram_r_req_i, ram_w_req_i, ram_addr_i, ram_w_data_i, ram_state_i,
      input  if_req_i, if_addr_i, mem_din, io_buffer_full,
      output ram_done_o, ram_r_data_o, if_done_o, if_data_o, mem_dout, mem_a, mem_wr
   );

   modport master (
      output ram_r_req_i, ram_w_req_i, ram_addr_i, ram_w_data_i, ram_state_i,
      output if_req_i, if_addr_i, mem_din, io_buffer_full,
      input  ram_done_o, ram_r_data_o, if_done_o, if_data_o, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises data/fetch requests onto a byte-wide RAM bus, one byte per cycle, little-endian,
// and returns a single-cycle done pulse with zero-extended read data.
module mem_ctrl #(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_SEL = 2'b11
) (
   input logic       clk,
   input logic       rst_n,
   input logic       rdy,
   mem_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, DRD, DWR, IFR, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        lst_q, lst_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0][7:0]   wdata_q, wdata_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       idata_q, idata_d;
   logic              fetch_q, fetch_d;
   logic              stall;
   logic [31:0]       rd_word;

   // A full IO buffer only blocks writes that target the IO window.
   assign stall   = (state_q == DWR) && bus.io_buffer_full && (addr_q[17:16] == IO_SEL);
   assign rd_word = rbuf_q | (32'(bus.mem_din) << {idx_q, 3'b000});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         lst_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         idata_q <= '0;
         fetch_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lst_q   <= lst_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         idata_q <= idata_d;
         fetch_q <= fetch_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lst_d   = lst_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      rdata_d = rdata_q;
      idata_d = idata_q;
      fetch_d = fetch_q;
      if (rdy) begin
         unique case (state_q)
            IDLE: begin
               if (bus.ram_w_req_i || bus.ram_r_req_i) begin
                  addr_d  = bus.ram_addr_i;
                  wdata_d = bus.ram_w_data_i;
                  lst_d   = (bus.ram_state_i == 2'b00) ? 2'd0 :
                            (bus.ram_state_i == 2'b01) ? 2'd1 : 2'd3;
                  idx_d   = '0;
                  rbuf_d  = '0;
                  fetch_d = 1'b0;
                  state_d = bus.ram_w_req_i ? DWR : DRD;
               end else if (bus.if_req_i) begin
                  addr_d  = bus.if_addr_i;
                  lst_d   = 2'd3;
                  idx_d   = '0;
                  rbuf_d  = '0;
                  fetch_d = 1'b1;
                  state_d = IFR;
               end
            end
            DRD, IFR: begin
               rbuf_d = rd_word;
               if (idx_q == lst_q) begin
                  state_d = DONE;
                  if (fetch_q) idata_d = rd_word;
                  else         rdata_d = rd_word;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            DWR: begin
               if (!stall) begin
                  if (idx_q == lst_q) state_d = DONE;
                  else                idx_d   = idx_q + 2'd1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Bus address/data follow the current byte index; mem_wr is gated by rdy and IO stall.
   always_comb begin
      bus.mem_a        = addr_q + ADDR_W'(idx_q);
      bus.mem_dout     = wdata_q[idx_q];
      bus.mem_wr       = (state_q == DWR) && rdy && !stall;
      bus.ram_done_o   = (state_q == DONE) && !fetch_q;
      bus.if_done_o    = (state_q == DONE) && fetch_q;
      bus.ram_r_data_o = rdata_q;
      bus.if_data_o    = idata_q;
   end

endmodule
